mem_responder: RTL and testbench

//  Memory-side responder for the accumulator CPU's multicycle datapath: serves
//  its mr/mw requests on a 13-bit byte address with 8-bit data. Adds a

---
 rtl/mem_resp_pkg.sv | 30 +++
 rtl/mem_responder_wait_counter.sv | 44 ++++
 rtl/mem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory responder:
//   - state_t       : responder FSM states (IDLE, WAIT, RESP)
//   - ADDR_W_DEF    : default address width (13 -> 8K words)
//   - DATA_W_DEF    : default data width (8)
//   - CNT_W         : wait-state counter width (4 bits, WAIT_CYCLES 0..15)
//   - even_parity() : parity bit that makes {parity, data} hold an even count
//                     of ones; callers zero-extend their data to PARITY_MAX_W.
// ----------------------------------------------------------------------------
package mem_resp_pkg;

    localparam int ADDR_W_DEF   = 13;
    localparam int DATA_W_DEF   = 8;
    localparam int CNT_W        = 4;
    localparam int PARITY_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Zero-extension does not change the XOR reduction, so one function
    // serves every data width up to PARITY_MAX_W.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_responder_wait_counter.sv
// ----------------------------------------------------------------------------
// wait_counter
// Loadable CNT_W-bit up-counter used by the responder FSM to time wait states.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; clears the count
//   i_load     in   load i_load_val (has priority over i_en)
//   i_load_val in   value loaded on i_load
//   i_en       in   increment by one
//   i_terminal in   terminal count
//   o_tc       out  high when the increment taken at the coming edge lands
//                   on i_terminal, so the FSM can leave on that same edge
// ----------------------------------------------------------------------------
module wait_counter
    import mem_resp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_terminal,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);
    assign o_tc        = i_en && (w_count_inc == i_terminal);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks evaluate in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the accumulator CPU multicycle datapath. Accepts a
// read (mr) or write (mw) request, inserts WAIT_CYCLES wait states, then pulses
// done for one cycle. Owns the DEPTH x DATA_W program/data array.
//
// Build option: define MEM_PARITY_EN to store an even parity bit per word and
// flag a mismatch on parity_err during the read's done cycle. Without it the
// array is DATA_W wide and parity_err is tied low. Ports are identical.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high; aborts any transaction
//   mr / mw     in   read / write request, held until done
//   address     in   ADDR_W request address, sampled at acceptance
//   dataMem     in   DATA_W write data, sampled at acceptance
//   memOut      out  read data, updated on read completion, held otherwise
//   done        out  one-cycle completion pulse
//   busy        out  high from acceptance until done inclusive
//   req_err     out  one-cycle pulse after mr and mw were both high in IDLE
//   parity_err  out  read parity mismatch, valid with done
// ----------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 2 ** ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mr,
    input  logic              mw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataMem,
    output logic [DATA_W-1:0] memOut,
    output logic              done,
    output logic              busy,
    output logic              req_err,
    output logic              parity_err
);

`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic [DATA_W-1:0] r_mem_out;
    logic              r_req_err;
    logic              r_parity_err;

    logic [MEM_W-1:0]  r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Control wires
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_conflict;
    logic              w_enter_resp;
    logic              w_cnt_load;
    logic              w_cnt_en;
    logic              w_cnt_tc;

    logic [ADDR_W-1:0] w_tx_addr;
    logic [DATA_W-1:0] w_tx_data;
    logic              w_tx_write;
    logic [MEM_W-1:0]  w_wr_word;
    logic [MEM_W-1:0]  w_rd_word;
    logic              w_rd_mismatch;

    wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val ({CNT_W{1'b0}}),
        .i_en       (w_cnt_en),
        .i_terminal (CNT_W'(WAIT_CYCLES)),
        .o_tc       (w_cnt_tc)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_conflict   = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;

        case (r_state)
            IDLE: begin
                if (mr ^ mw) begin
                    w_accept   = 1'b1;
                    w_cnt_load = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                    end
                end else if (mr && mw) begin
                    w_conflict = 1'b1;
                end
            end
            WAIT: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);

    // With zero wait states the access happens on the acceptance edge itself,
    // before the request has been latched, so take it straight from the ports.
    assign w_tx_addr  = w_accept ? address : r_addr;
    assign w_tx_data  = w_accept ? dataMem : r_wdata;
    assign w_tx_write = w_accept ? mw      : r_is_write;

    assign w_rd_word  = r_mem[w_tx_addr];

`ifdef MEM_PARITY_EN
    assign w_wr_word     = {even_parity(PARITY_MAX_W'(w_tx_data)), w_tx_data};
    assign w_rd_mismatch = w_rd_word[DATA_W]
                           != even_parity(PARITY_MAX_W'(w_rd_word[DATA_W-1:0]));
`else
    assign w_wr_word     = w_tx_data;
    assign w_rd_mismatch = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_mem_out    <= '0;
            r_req_err    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= address;
                r_wdata    <= dataMem;
                r_is_write <= mw;
            end
            if (w_enter_resp && !w_tx_write) begin
                r_mem_out <= w_rd_word[DATA_W-1:0];
            end
            r_req_err    <= w_conflict;
            // RESP is only ever entered from another state and lasts one
            // cycle, so this lines up exactly with done.
            r_parity_err <= w_enter_resp && !w_tx_write && w_rd_mismatch;
        end
    end

    // NOTE: the array has no reset branch; clearing 8K words is not a real
    // memory operation and would stop it mapping onto RAM. Reset only gates
    // the commit so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_tx_write) begin
            r_mem[w_tx_addr] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign memOut     = r_mem_out;
    assign done       = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign req_err    = r_req_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
// Two responders: dut2 with two wait states and dut0 with none. A table of
// transactions with hand-computed memOut and latency drives both, followed by
// hand-written sequences for back-to-back reads, request conflict, reset abort,
// input changes after acceptance and the parity build option.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk;

    logic        rst2, mr2, mw2;
    logic [12:0] addr2;
    logic [7:0]  din2, dout2;
    logic        done2, busy2, rerr2, perr2;

    logic        rst0, mr0, mw0;
    logic [12:0] addr0;
    logic [7:0]  din0, dout0;
    logic        done0, busy0, rerr0, perr0;

    int n_checks;
    int n_pass;

    mem_responder #(.ADDR_W(13), .DATA_W(8), .DEPTH(8192), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(rst2), .mr(mr2), .mw(mw2), .address(addr2),
        .dataMem(din2), .memOut(dout2), .done(done2), .busy(busy2),
        .req_err(rerr2), .parity_err(perr2)
    );

    mem_responder #(.ADDR_W(13), .DATA_W(8), .DEPTH(8192), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .mr(mr0), .mw(mw0), .address(addr0),
        .dataMem(din0), .memOut(dout0), .done(done0), .busy(busy0),
        .req_err(rerr0), .parity_err(perr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;      // 0 -> dut0, 2 -> dut2
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_mem;  // memOut after completion
        int          exp_lat;  // edges from acceptance (inclusive) to done
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock and sample #1 after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [12:0] a, input logic [7:0] d);
        if (sel == 0) begin
            mr0 = r; mw0 = w; addr0 = a; din0 = d;
        end else begin
            mr2 = r; mw2 = w; addr2 = a; din2 = d;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : done2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy2;
    endfunction

    function automatic logic [7:0] get_mem(input int sel);
        return (sel == 0) ? dout0 : dout2;
    endfunction

    function automatic logic get_perr(input int sel);
        return (sel == 0) ? perr0 : perr2;
    endfunction

    // Issue one request, hold it until done (bounded), then release it.
    task automatic run_txn(input int sel, input logic wr, input logic [12:0] a,
                           input logic [7:0] d, input logic [7:0] exp_mem,
                           input int exp_lat, input string tag);
        int   lat;
        int   k;
        logic busy_ok;
        lat     = 99;
        k       = 0;
        busy_ok = 1'b1;
        drive(sel, !wr, wr, a, d);
        while (k < 20 && lat == 99) begin
            step();
            k++;
            if (!get_busy(sel)) busy_ok = 1'b0;
            if (get_done(sel)) lat = k;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy window"}, busy_ok, 1);
        check({tag, " memOut"}, get_mem(sel), exp_mem);
        check({tag, " parity_err"}, get_perr(sel), 0);
        drive(sel, 1'b0, 1'b0, a, d);
        step();
        check({tag, " done after"}, get_done(sel), 0);
        check({tag, " busy after"}, get_busy(sel), 0);
    endtask

    initial begin
        int   k;
        logic seen;

        n_checks = 0;
        n_pass   = 0;

        //          sel wr  addr       data   exp_mem lat
        vecs[0] = '{2, 1'b1, 13'h1ABC, 8'h5A, 8'h00, 3};
        vecs[1] = '{2, 1'b0, 13'h1ABC, 8'h00, 8'h5A, 3};
        vecs[2] = '{2, 1'b1, 13'h0010, 8'h00, 8'h5A, 3};
        vecs[3] = '{2, 1'b1, 13'h0200, 8'h12, 8'h5A, 3};
        vecs[4] = '{2, 1'b1, 13'h1FFF, 8'h3C, 8'h5A, 3};
        vecs[5] = '{2, 1'b0, 13'h0010, 8'h00, 8'h00, 3};
        vecs[6] = '{2, 1'b0, 13'h1FFF, 8'h00, 8'h3C, 3};
        vecs[7] = '{0, 1'b1, 13'h0000, 8'h11, 8'h00, 1};
        vecs[8] = '{0, 1'b1, 13'h1FFF, 8'hEE, 8'h00, 1};
        vecs[9] = '{0, 1'b0, 13'h0000, 8'h00, 8'h11, 1};

        rst2 = 1'b1; rst0 = 1'b1;
        drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
        drive(2, 1'b0, 1'b0, 13'h0, 8'h0);
        step();
        step();
        rst2 = 1'b0; rst0 = 1'b0;

        // Reset state
        check("reset done2", done2, 0);
        check("reset busy2", busy2, 0);
        check("reset memOut2", dout2, 8'h00);
        check("reset req_err2", rerr2, 0);
        check("reset parity_err2", perr2, 0);
        check("reset busy0", busy0, 0);
        check("reset memOut0", dout0, 8'h00);

        // Table of single transactions
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].exp_mem, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Zero wait states, mr held across done: pulses two cycles apart
        drive(0, 1'b1, 1'b0, 13'h0000, 8'h00);
        step();
        check("b2b first done", done0, 1);
        check("b2b first memOut", dout0, 8'h11);
        drive(0, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        step();
        check("b2b gap done", done0, 0);
        step();
        check("b2b second done", done0, 1);
        check("b2b second memOut", dout0, 8'hEE);
        drive(0, 1'b0, 1'b0, 13'h0, 8'h00);
        step();
        check("b2b after done", done0, 0);

        // mr and mw together: req_err pulse, no access
        drive(2, 1'b1, 1'b1, 13'h1ABC, 8'h00);
        step();
        check("conflict req_err", rerr2, 1);
        check("conflict busy", busy2, 0);
        check("conflict done", done2, 0);
        drive(2, 1'b0, 1'b0, 13'h1ABC, 8'h00);
        step();
        check("conflict req_err drop", rerr2, 0);
        check("conflict no done", done2, 0);
        run_txn(2, 1'b0, 13'h1ABC, 8'h00, 8'h5A, 3, "conflict readback");

        // Reset one edge after acceptance aborts the write
        drive(2, 1'b0, 1'b1, 13'h0010, 8'hFF);
        step();
        check("abort accepted busy", busy2, 1);
        rst2 = 1'b1;
        drive(2, 1'b0, 1'b0, 13'h0010, 8'hFF);
        step();
        rst2 = 1'b0;
        check("abort busy", busy2, 0);
        check("abort done", done2, 0);
        check("abort memOut cleared", dout2, 8'h00);
        seen = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            if (done2) seen = 1'b1;
        end
        check("abort no late done", seen, 0);
        run_txn(2, 1'b0, 13'h0010, 8'h00, 8'h00, 3, "abort readback");

        // Address/data changed after acceptance: latched values win
        drive(2, 1'b0, 1'b1, 13'h0100, 8'h77);
        step();
        drive(2, 1'b0, 1'b1, 13'h0200, 8'h99);
        k = 0;
        seen = 1'b0;
        while (k < 20 && !seen) begin
            step();
            k++;
            if (done2) seen = 1'b1;
        end
        check("latch done latency", k, 2);
        drive(2, 1'b0, 1'b0, 13'h0, 8'h00);
        step();
        run_txn(2, 1'b0, 13'h0100, 8'h00, 8'h77, 3, "latch target");
        run_txn(2, 1'b0, 13'h0200, 8'h00, 8'h12, 3, "latch untouched");

`ifdef MEM_PARITY_EN
        // Corrupt the stored parity bit, then read it back
        run_txn(2, 1'b1, 13'h0300, 8'h3C, 8'h12, 3, "parity write");
        dut2.r_mem[13'h0300] = dut2.r_mem[13'h0300] ^ 9'h100;
        drive(2, 1'b1, 1'b0, 13'h0300, 8'h00);
        k = 0;
        seen = 1'b0;
        while (k < 20 && !seen) begin
            step();
            k++;
            if (done2) seen = 1'b1;
        end
        check("parity latency", k, 3);
        check("parity_err on bad word", perr2, 1);
        check("parity memOut", dout2, 8'h3C);
        drive(2, 1'b0, 1'b0, 13'h0, 8'h00);
        step();
        check("parity_err drop", perr2, 0);
`else
        run_txn(2, 1'b0, 13'h1FFF, 8'h00, 8'h3C, 3, "no parity build");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
